// File: rtl/blink_rate_controller.sv
// blink_rate_controller
// Start/stop and rate-select sequencer for the LED blink timer.
// Two raw push buttons are synchronised and edge-detected into one-cycle
// events. The events drive a two-state FSM (STOPPED/RUNNING) and a 7-entry
// rate preset index. A single period counter runs while RUNNING. At the end
// of each preset period it raises a one-cycle elapse pulse and toggles the LED.

module blink_rate_controller #(
    parameter int unsigned COUNT_100HZ   = 500000,
    parameter int unsigned COUNTER_WIDTH = 26
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       button_start_stop,
    input  logic       button_next,
    output logic       led,
    output logic       timer_elapsed,
    output logic       running,
    output logic [2:0] freq_sel
);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_e;

    // Terminal counts (period - 1) for each preset, 1 Hz .. 100 Hz.
    localparam logic [COUNTER_WIDTH-1:0] TC_1HZ   = COUNTER_WIDTH'(100 * COUNT_100HZ - 1);
    localparam logic [COUNTER_WIDTH-1:0] TC_2HZ   = COUNTER_WIDTH'(50 * COUNT_100HZ - 1);
    localparam logic [COUNTER_WIDTH-1:0] TC_5HZ   = COUNTER_WIDTH'(20 * COUNT_100HZ - 1);
    localparam logic [COUNTER_WIDTH-1:0] TC_10HZ  = COUNTER_WIDTH'(10 * COUNT_100HZ - 1);
    localparam logic [COUNTER_WIDTH-1:0] TC_20HZ  = COUNTER_WIDTH'(5 * COUNT_100HZ - 1);
    localparam logic [COUNTER_WIDTH-1:0] TC_50HZ  = COUNTER_WIDTH'(2 * COUNT_100HZ - 1);
    localparam logic [COUNTER_WIDTH-1:0] TC_100HZ = COUNTER_WIDTH'(COUNT_100HZ - 1);

    // Button conditioning flops: two synchroniser stages plus an edge-detect stage.
    logic ss_meta_q, ss_sync_q, ss_prev_q;
    logic nx_meta_q, nx_sync_q, nx_prev_q;
    logic ss_evt, nx_evt;

    // Control state.
    state_e                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic [2:0]               freq_sel_q, freq_sel_d;
    logic                     led_q, led_d;
    logic                     elapsed_q, elapsed_d;
    logic                     running_q, running_d;

    logic [COUNTER_WIDTH-1:0] period_tc;
    logic [2:0]               freq_sel_inc;

    // Synchronise both buttons into the clock domain and keep one delayed copy for edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ss_meta_q <= 1'b0;
            ss_sync_q <= 1'b0;
            ss_prev_q <= 1'b0;
            nx_meta_q <= 1'b0;
            nx_sync_q <= 1'b0;
            nx_prev_q <= 1'b0;
        end else begin
            ss_meta_q <= button_start_stop;
            ss_sync_q <= ss_meta_q;
            ss_prev_q <= ss_sync_q;
            nx_meta_q <= button_next;
            nx_sync_q <= nx_meta_q;
            nx_prev_q <= nx_sync_q;
        end
    end

    // A rising edge on the synchronised level gives exactly one event per press.
    assign ss_evt = ss_sync_q & ~ss_prev_q;
    assign nx_evt = nx_sync_q & ~nx_prev_q;

    // Select the terminal count for the current preset. Index 7 falls back to 1 Hz.
    always_comb begin
        period_tc = TC_1HZ;
        case (freq_sel_q)
            3'd0:    period_tc = TC_1HZ;
            3'd1:    period_tc = TC_2HZ;
            3'd2:    period_tc = TC_5HZ;
            3'd3:    period_tc = TC_10HZ;
            3'd4:    period_tc = TC_20HZ;
            3'd5:    period_tc = TC_50HZ;
            3'd6:    period_tc = TC_100HZ;
            default: period_tc = TC_1HZ;
        endcase
    end

    // Advance the preset index. It wraps 6 -> 0. A stray 7 is treated as 0, so it advances to 1.
    always_comb begin
        freq_sel_inc = freq_sel_q + 3'd1;
        case (freq_sel_q)
            3'd6:    freq_sel_inc = 3'd0;
            3'd7:    freq_sel_inc = 3'd1;
            default: freq_sel_inc = freq_sel_q + 3'd1;
        endcase
    end

    // Next-state logic: button events take priority over the period terminal count.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        freq_sel_d = freq_sel_q;
        led_d      = led_q;
        elapsed_d  = 1'b0;

        if (ss_evt || nx_evt) begin
            // Any event restarts the period. An event on the terminal-count
            // cycle suppresses that cycle's elapse and toggle.
            count_d = '0;
            if (ss_evt) begin
                if (state_q == RUNNING) begin
                    state_d = STOPPED;
                    led_d   = 1'b0;
                end else begin
                    state_d = RUNNING;
                end
            end
            if (nx_evt) begin
                freq_sel_d = freq_sel_inc;
            end
        end else if (state_q == RUNNING) begin
            if (count_q == period_tc) begin
                count_d   = '0;
                elapsed_d = 1'b1;
                led_d     = ~led_q;
            end else begin
                count_d = count_q + COUNTER_WIDTH'(1);
            end
        end else begin
            count_d = '0;
            led_d   = 1'b0;
        end

        running_d = (state_d == RUNNING);
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered output flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            freq_sel_q <= '0;
            led_q      <= 1'b0;
            elapsed_q  <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            freq_sel_q <= freq_sel_d;
            led_q      <= led_d;
            elapsed_q  <= elapsed_d;
            running_q  <= running_d;
        end
    end

    assign led           = led_q;
    assign timer_elapsed = elapsed_q;
    assign running       = running_q;
    assign freq_sel      = freq_sel_q;

endmodule

// File: tb/tb_blink_rate_controller.sv
// Testbench for blink_rate_controller.
// A behavioural model tracks button events from raw input history.
// It also tracks the run flag, preset index, LED level and the cycle at which the period last restarted.
// It predicts an elapse when the distance to that restart is a multiple of the preset period.

module tb_blink_rate_controller;

    localparam int unsigned C = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       b_ss = 1'b0;
    logic       b_nx = 1'b0;
    logic       led, timer_elapsed, running;
    logic [2:0] freq_sel;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Model state
    int unsigned cyc = 0;
    int unsigned r_cyc = 0;
    int unsigned m_sel = 0;
    int unsigned te_seen = 0;
    bit          m_run = 1'b0;
    bit          m_led = 1'b0;
    bit          m_te = 1'b0;
    bit          hs0, hs1, hs2, hn0, hn1, hn2;
    int unsigned per_mult[7] = '{100, 50, 20, 10, 5, 2, 1};

    blink_rate_controller #(
        .COUNT_100HZ   (C),
        .COUNTER_WIDTH (10)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .button_start_stop (b_ss),
        .button_next       (b_nx),
        .led               (led),
        .timer_elapsed     (timer_elapsed),
        .running           (running),
        .freq_sel          (freq_sel)
    );

    always #5 clock = ~clock;

    // Model update and per-cycle compare
    initial begin
        bit ev_ss, ev_nx;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_run = 0; m_led = 0; m_te = 0; m_sel = 0;
                {hs0, hs1, hs2, hn0, hn1, hn2} = '0;
                #1;
                tests++;
                if (led !== 1'b0 || timer_elapsed !== 1'b0 || running !== 1'b0 || freq_sel !== 3'd0) begin
                    fails++;
                    $display("FAIL reset_state: led=%b te=%b run=%b sel=%0d, required all 0",
                             led, timer_elapsed, running, freq_sel);
                end
            end else begin
                cyc++;
                ev_ss = hs1 & ~hs2;
                ev_nx = hn1 & ~hn2;
                hs2 = hs1; hs1 = hs0; hs0 = b_ss;
                hn2 = hn1; hn1 = hn0; hn0 = b_nx;
                m_te = 0;
                if (ev_ss || ev_nx) begin
                    if (ev_ss) begin
                        if (m_run) m_led = 0;
                        m_run = !m_run;
                    end
                    if (ev_nx) m_sel = (m_sel + 1) % 7;
                    r_cyc = cyc;
                end else if (m_run) begin
                    if ((cyc - r_cyc) % (per_mult[m_sel] * C) == 0) begin
                        m_te = 1;
                        m_led = !m_led;
                    end
                end
                #1;
                tests++;
                if (led !== m_led || timer_elapsed !== m_te || running !== m_run || freq_sel !== 3'(m_sel)) begin
                    fails++;
                    $display("FAIL cycle %0d: led=%b te=%b run=%b sel=%0d, required led=%b te=%b run=%b sel=%0d",
                             cyc, led, timer_elapsed, running, freq_sel, m_led, m_te, m_run, m_sel);
                end
                if (timer_elapsed === 1'b1) te_seen++;
            end
        end
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic press(input bit which_next, input int len);
        @(negedge clock);
        if (which_next) b_nx = 1'b1;
        else            b_ss = 1'b1;
        repeat (len) @(negedge clock);
        b_nx = 1'b0;
        b_ss = 1'b0;
    endtask

    // Wait for an elapse pulse with a cycle budget; returns the cycle number it appeared on.
    task automatic wait_te(input int bound, output int unsigned at);
        at = 0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clock);
            #2;
            if (timer_elapsed === 1'b1) begin
                at = cyc;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL wait_te: no elapse within %0d cycles, required one", bound);
    endtask

    // Press a button once and step to the edge where its event is applied (third edge).
    task automatic press_and_settle(input bit which_next);
        press(which_next, 1);
        @(posedge clock); #2;
        @(posedge clock); #2;
    endtask

    initial begin
        int unsigned ce, a, b, e, e2, t0;
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned ce, a, b, e, e2, t0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Idle after reset
        repeat (1000) @(posedge clock);
        #2;
        chk("idle_led", led, 0);
        chk("idle_running", running, 0);
        chk("idle_sel", freq_sel, 0);
        chk("idle_elapses", te_seen, 0);

        // Start: running appears on the third edge
        press(1'b0, 1);
        @(posedge clock); #2;
        chk("start_edge2_running", running, 0);
        @(posedge clock); #2;
        chk("start_edge3_running", running, 1);
        ce = cyc;
        wait_te(1000, a);
        chk("first_period", a - ce, 400);
        chk("led_after_1st", led, 1);
        wait_te(1000, b);
        chk("second_period", b - a, 400);
        chk("led_after_2nd", led, 0);

        // Step through presets
        for (int i = 1; i <= 6; i++) begin
            press_and_settle(1'b1);
            chk($sformatf("sel_step_%0d", i), freq_sel, i);
            repeat (45) @(negedge clock);
        end
        wait_te(100, a);
        wait_te(100, b);
        chk("period_sel6", b - a, 4);
        press_and_settle(1'b1);
        chk("sel_wrap", freq_sel, 0);
        wait_te(1000, a);
        wait_te(1000, b);
        chk("period_sel0_again", b - a, 400);

        // next event lands on the terminal-count cycle (edge e+400)
        e = b;
        repeat (397) @(posedge clock);
        #2;
        press(1'b1, 1);
        wait_te(1000, e2);
        chk("next_on_tc_gap", e2 - e, 600);
        chk("next_on_tc_sel", freq_sel, 1);

        // Stop while led is high
        for (int i = 0; i < 4 && led !== 1'b1; i++) wait_te(1000, a);
        chk("led_high_before_stop", led, 1);
        press(1'b0, 1);
        @(posedge clock); #2;
        @(posedge clock); #2;
        chk("stop_running", running, 0);
        chk("stop_led", led, 0);
        t0 = te_seen;
        repeat (1000) @(posedge clock);
        #2;
        chk("stopped_no_elapse", te_seen - t0, 0);

        // Async reset mid-run at sel=3 with led=1
        press_and_settle(1'b0);
        press_and_settle(1'b1);
        press_and_settle(1'b1);
        chk("pre_reset_sel", freq_sel, 3);
        for (int i = 0; i < 4 && led !== 1'b1; i++) wait_te(200, a);
        chk("pre_reset_led", led, 1);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_led", led, 0);
        chk("async_running", running, 0);
        chk("async_sel", freq_sel, 0);
        chk("async_te", timer_elapsed, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Held next button yields one step
        press(1'b1, 100);
        repeat (5) @(posedge clock);
        #2;
        chk("held_next_sel", freq_sel, 1);

        // Randomised phase
        for (int i = 0; i < 6000; i++) begin
            @(negedge clock);
            b_nx = ($urandom_range(0, 99) < 3);
            b_ss = ($urandom_range(0, 299) < 2);
            if (i == 3000) begin
                b_nx = 1'b0;
                b_ss = 1'b0;
                @(posedge clock);
                #3;
                reset_n = 1'b0;
                repeat (2) @(negedge clock);
                reset_n = 1'b1;
            end
        end
        b_nx = 1'b0;
        b_ss = 1'b0;
        repeat (5) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
